puf_response_builder: RTL and testbench

//   Measurement sequencer that sits downstream of the dual RO-bank/counter pair.
//   It steps the 5-bit challenge, clears the RO counters, and gates the oscillators
//   for a fixed window. It then freezes them and compares the two counts to produce
//   one response bit per challenge.

---
 rtl/puf_pkg.sv | 26 ++
 rtl/puf_phase_timer.sv | 26 ++
 rtl/puf_response_builder.sv | 164 ++++++++++++++++
 tb/tb_puf_response_builder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and default constants for the PUF response builder slice.
package puf_pkg;

    localparam int CHAL_W      = 5;
    localparam int DEF_CW      = 8;
    localparam int DEF_NBITS   = 16;
    localparam int DEF_WINDOW  = 64;
    localparam int DEF_SETTLE  = 4;
    localparam int DEF_CLR_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } puf_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/puf_phase_timer.sv
// Loadable down-counter with a zero flag; times the CLEAR, MEASURE and SETTLE phases.
module puf_phase_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/puf_response_builder.sv
// Challenge sequencer for the dual RO bank: clear, gate, settle, compare, assemble NBITS bits.
// Optional 3-pass majority vote per challenge when PUF_MAJORITY_EN is defined.
module puf_response_builder
    import puf_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int NBITS   = DEF_NBITS,
    parameter int WINDOW  = DEF_WINDOW,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int CLR_CYC = DEF_CLR_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CHAL_W-1:0]          base_challenge,
    input  logic [CW-1:0]              count_a,
    input  logic [CW-1:0]              count_b,
    output logic                       ro_en,
    output logic                       ro_clr,
    output logic [CHAL_W-1:0]          challenge,
    output logic [NBITS-1:0]           resp,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       busy,
    output logic [$clog2(NBITS+1)-1:0] tie_cnt
);

    localparam int TW = $clog2(max3(WINDOW, SETTLE, CLR_CYC) + 1);
    localparam int IW = $clog2(NBITS + 1);

    puf_state_t        r_state, w_state_next;
    logic              w_load;
    logic [TW-1:0]     w_load_val;
    logic              w_zero;
    logic [CHAL_W-1:0] r_base, r_chal;
    logic [NBITS-1:0]  r_resp;
    logic [IW-1:0]     r_tie, r_idx;
    logic              r_ro_en, r_ro_clr, r_valid, r_busy;
    logic              w_gt, w_tie, w_bit, w_tie_bit, w_last_pass, w_last_bit;

    assign w_gt       = (count_a > count_b);
    assign w_tie      = (count_a == count_b);
    assign w_last_bit = (r_idx == IW'(NBITS - 1));

`ifdef PUF_MAJORITY_EN
    logic [1:0] r_pass, r_wins, w_votes;
    logic       r_any_tie;

    // wins never exceeds 2 before the final pass, so the 2-bit sum cannot overflow
    assign w_votes     = r_wins + {1'b0, w_gt};
    assign w_bit       = w_votes[1];
    assign w_tie_bit   = r_any_tie | w_tie;
    assign w_last_pass = (r_pass == 2'd2);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pass    <= '0;
            r_wins    <= '0;
            r_any_tie <= 1'b0;
        end else if ((r_state == ST_IDLE && start) || (r_state == ST_COMPARE && w_last_pass)) begin
            r_pass    <= '0;
            r_wins    <= '0;
            r_any_tie <= 1'b0;
        end else if (r_state == ST_COMPARE) begin
            r_pass    <= r_pass + 1'b1;
            r_wins    <= w_votes;
            r_any_tie <= w_tie_bit;
        end
    end
`else
    assign w_bit       = w_gt;
    assign w_tie_bit   = w_tie;
    assign w_last_pass = 1'b1;
`endif

    puf_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            ST_IDLE: if (start) begin
                w_state_next = ST_CLEAR;
                w_load       = 1'b1;
                w_load_val   = TW'(CLR_CYC - 1);
            end
            ST_CLEAR: if (w_zero) begin
                w_state_next = ST_MEASURE;
                w_load       = 1'b1;
                w_load_val   = TW'(WINDOW - 1);
            end
            ST_MEASURE: if (w_zero) begin
                w_state_next = ST_SETTLE;
                w_load       = 1'b1;
                w_load_val   = TW'(SETTLE - 1);
            end
            ST_SETTLE: if (w_zero) w_state_next = ST_COMPARE;
            ST_COMPARE: begin
                if (w_last_pass && w_last_bit) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CLEAR;
                    w_load       = 1'b1;
                    w_load_val   = TW'(CLR_CYC - 1);
                end
            end
            ST_DONE: if (resp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with state residency.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_ro_en  <= 1'b0;
            r_ro_clr <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_base   <= '0;
            r_chal   <= '0;
            r_resp   <= '0;
            r_tie    <= '0;
            r_idx    <= '0;
        end else begin
            r_ro_clr <= (w_state_next == ST_CLEAR);
            r_ro_en  <= (w_state_next == ST_MEASURE);
            r_busy   <= (w_state_next != ST_IDLE);
            r_valid  <= (w_state_next == ST_DONE);
            if (r_state == ST_IDLE && start) begin
                r_base <= base_challenge;
                r_chal <= base_challenge;
                r_resp <= '0;
                r_tie  <= '0;
                r_idx  <= '0;
            end else if (r_state == ST_COMPARE && w_last_pass) begin
                r_resp <= r_resp | (NBITS'(w_bit) << r_idx);
                if (w_tie_bit) r_tie <= r_tie + 1'b1;
                r_idx  <= r_idx + 1'b1;
                r_chal <= r_base + CHAL_W'(r_idx) + CHAL_W'(1);
            end
        end
    end

    assign ro_en      = r_ro_en;
    assign ro_clr     = r_ro_clr;
    assign challenge  = r_chal;
    assign resp       = r_resp;
    assign resp_valid = r_valid;
    assign busy       = r_busy;
    assign tie_cnt    = r_tie;

endmodule

// File: tb/tb_puf_response_builder.sv
// Self-checking bench for puf_response_builder: directed table, random runs vs. a bit-level model,
// mid-run reset and DONE back-pressure sequences. Honours PUF_MAJORITY_EN.
module tb_puf_response_builder;
    import puf_pkg::*;

    localparam int CW      = 8;
    localparam int NBITS   = 16;
    localparam int WINDOW  = 64;
    localparam int SETTLE  = 4;
    localparam int CLR_CYC = 2;
    localparam int T       = CLR_CYC + WINDOW + SETTLE + 1;
`ifdef PUF_MAJORITY_EN
    localparam int PASSES  = 3;
`else
    localparam int PASSES  = 1;
`endif
    localparam int TCW     = $clog2(NBITS + 1);
    localparam int BUDGET  = NBITS * T * PASSES + 50;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4:0]        base_challenge;
    logic [CW-1:0]     count_a, count_b;
    logic              ro_en, ro_clr;
    logic [4:0]        challenge;
    logic [NBITS-1:0]  resp;
    logic              resp_valid;
    logic              resp_ready;
    logic              busy;
    logic [TCW-1:0]    tie_cnt;

    always #5 clk = ~clk;

    puf_response_builder #(
        .CW(CW), .NBITS(NBITS), .WINDOW(WINDOW), .SETTLE(SETTLE), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_challenge(base_challenge),
        .count_a(count_a), .count_b(count_b), .ro_en(ro_en), .ro_clr(ro_clr),
        .challenge(challenge), .resp(resp), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .busy(busy), .tie_cnt(tie_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- RO bank model ----------------
    int            mode = 0;
    logic [CW-1:0] a_tab [32];
    logic [CW-1:0] b_tab [32];

    // mode 4: even challenges win 2 of 3 passes, odd challenges win 1 of 3
    function automatic logic [CW-1:0] get_a(input int md, input int ch, input int p);
        case (md)
            0: return 8'd200;
            1: return (ch % 2 == 0) ? 8'd150 : 8'd90;
            2: return a_tab[ch];
            3: return 8'd77;
            4: return (((ch % 2) == 0) != ((p % 2) == 1)) ? 8'd150 : 8'd90;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [CW-1:0] get_b(input int md, input int ch, input int p);
        case (md)
            0: return 8'd100;
            1: return (ch % 2 == 0) ? 8'd90 : 8'd150;
            2: return b_tab[ch];
            3: return 8'd77;
            4: return (get_a(md, ch, p) == 8'd150) ? 8'd90 : 8'd150;
            default: return 8'd0;
        endcase
    endfunction

    task automatic model(input int md, input logic [4:0] b, output logic [15:0] r, output int t);
        r = '0;
        t = 0;
        for (int i = 0; i < NBITS; i++) begin
            int ch;
            int wins;
            bit tie;
            ch = (int'(b) + i) % 32;
            wins = 0;
            tie = 0;
            for (int p = 0; p < PASSES; p++) begin
                if (get_a(md, ch, p) > get_b(md, ch, p)) wins++;
                if (get_a(md, ch, p) == get_b(md, ch, p)) tie = 1;
            end
            r[i] = (2 * wins > PASSES);
            if (tie) t++;
        end
    endtask

    // ---------------- monitor (negedge) ----------------
    int         m_meas, en_run, clr_run, overlap, chal_err, settle_left, pidx;
    int         en_runs[$];
    int         clr_runs[$];
    int         chal_q[$];
    logic       prev_en = 1'b0;
    logic [4:0] prev_chal = '0;

    always @(negedge clk) begin
        if (start && !busy && !rst_n) begin
            m_meas = 0; en_run = 0; clr_run = 0; overlap = 0; chal_err = 0; settle_left = 0;
            en_runs.delete(); clr_runs.delete(); chal_q.delete();
        end else begin
            if (ro_en && ro_clr) overlap++;
            if (ro_en && !prev_en) chal_q.push_back(int'(challenge));
            if (ro_en && prev_en && challenge != prev_chal) chal_err++;
            if (settle_left > 0) begin
                if (challenge != prev_chal) chal_err++;
                settle_left--;
            end
            if (!ro_en && prev_en) begin
                m_meas++;
                settle_left = SETTLE;
            end
            if (ro_en) en_run++;
            else if (en_run != 0) begin en_runs.push_back(en_run); en_run = 0; end
            if (ro_clr) clr_run++;
            else if (clr_run != 0) begin clr_runs.push_back(clr_run); clr_run = 0; end
        end
        prev_en   = ro_en;
        prev_chal = challenge;
        pidx      = (m_meas == 0) ? 0 : (m_meas - 1) % PASSES;
        count_a  <= get_a(mode, int'(challenge), pidx);
        count_b  <= get_b(mode, int'(challenge), pidx);
    end

    // ---------------- run / check tasks ----------------
    int lat;

    task automatic run(input int md, input logic [4:0] b);
        @(posedge clk); #1;
        mode = md;
        base_challenge = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!resp_valid && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_run(input string tag, input int md, input logic [4:0] b,
                             input logic [15:0] exp_resp, input int exp_tie, input int hold);
        int bad;
        int stable_err;
        logic [15:0] held;
        chk({tag, " latency"}, lat, NBITS * T * PASSES);
        chk({tag, " resp"}, resp, exp_resp);
        chk({tag, " tie_cnt"}, tie_cnt, exp_tie);
        chk({tag, " busy in DONE"}, busy, 1);
        chk({tag, " meas count"}, chal_q.size(), NBITS * PASSES);
        bad = 0;
        foreach (chal_q[k]) if (chal_q[k] != (int'(b) + k / PASSES) % 32) bad++;
        chk({tag, " chal seq errs"}, bad, 0);
        bad = 0;
        foreach (en_runs[k]) if (en_runs[k] != WINDOW) bad++;
        chk({tag, " ro_en windows"}, en_runs.size() + 1000 * bad, NBITS * PASSES);
        bad = 0;
        foreach (clr_runs[k]) if (clr_runs[k] != CLR_CYC) bad++;
        chk({tag, " ro_clr windows"}, clr_runs.size() + 1000 * bad, NBITS * PASSES);
        chk({tag, " en/clr overlap"}, overlap, 0);
        chk({tag, " chal stable"}, chal_err, 0);
        held = resp;
        stable_err = 0;
        for (int c = 0; c < hold; c++) begin
            start = (c % 2 == 0);
            @(posedge clk); #1;
            if (!resp_valid || resp != held || !busy) stable_err++;
        end
        start = 1'b0;
        if (hold > 0) chk({tag, " DONE hold"}, stable_err, 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, " valid drop"}, resp_valid, 0);
        chk({tag, " idle after ready"}, busy, 0);
        stable_err = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (busy || resp != held) stable_err++;
        end
        chk({tag, " stays idle"}, stable_err, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " ro_en"}, ro_en, 0);
        chk({tag, " ro_clr"}, ro_clr, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " outs"}, {challenge, resp, resp_valid, tie_cnt}, 0);
    endtask

    typedef struct {
        int          md;
        logic [4:0]  b;
        logic [15:0] exp_resp;
        int          exp_tie;
        int          hold;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic [15:0] mr;
        int mt;
        int w;

        tbl.push_back('{0, 5'd0,  16'hFFFF, 0,  0});
        tbl.push_back('{1, 5'd0,  16'h5555, 0,  0});
        tbl.push_back('{1, 5'd30, 16'h5555, 0,  0});
        tbl.push_back('{3, 5'd0,  16'h0000, 16, 0});
        tbl.push_back('{4, 5'd0,  16'h5555, 0,  10});

        rst_n = 1'b1; start = 1'b0; resp_ready = 1'b0; base_challenge = '0;
        foreach (a_tab[k]) begin a_tab[k] = '0; b_tab[k] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b0;

        foreach (tbl[k]) begin
            v = tbl[k];
            run(v.md, v.b);
            check_run($sformatf("vec%0d", k), v.md, v.b, v.exp_resp, v.exp_tie, v.hold);
        end

        // reset pulse in the middle of a measurement window
        @(posedge clk); #1;
        mode = 0; base_challenge = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!ro_en && w < 100) begin @(posedge clk); #1; w++; end
        chk("midreset reached MEASURE", ro_en, 1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_reset_vals("midreset async");
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("midreset after");
        run(0, 5'd0);
        check_run("post-reset", 0, 5'd0, 16'hFFFF, 0, 0);

        // random RO tables with small values so ties are common
        for (int r = 0; r < 4; r++) begin
            logic [4:0] rb;
            foreach (a_tab[k]) begin
                a_tab[k] = CW'($urandom_range(0, 3));
                b_tab[k] = CW'($urandom_range(0, 3));
            end
            rb = 5'($urandom_range(0, 31));
            model(2, rb, mr, mt);
            run(2, rb);
            check_run($sformatf("rand%0d", r), 2, rb, mr, mt, (r == 0) ? 5 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
